mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// - Sole master of memory_bus in the von Neumann core. Arbitrates instruction fetch and load/store onto the one bus port.
// - Generates byteen and replicated store data.
// - Aligns and sign/zero-extends load data.
// - Flags misaligned data accesses without touching the bus.
// PARAMETERS
// - WIDTH  32  address/data width; byte-lane logic is fixed at 4 lanes (WIDTH=32 only)
// PORTS
// - clk            in   1      clock, rising edge
// - rst            in   1      reset, synchronous, active-high
// - if_req         in   1      fetch request; held until if_ready
// - if_addr        in   WIDTH  fetch address (word aligned)
// - if_ready       out  1      1-cycle pulse: if_instr valid
// - if_instr       out  WIDTH  fetched instruction
// - ls_req         in   1      load/store request; held until ls_ready
// - ls_we          in   1      1=store, 0=load
// - ls_size        in   2      00 byte, 01 half, 10 word (11 illegal -> treated as misaligned)
// - ls_unsigned    in   1      load zero-extends when 1
// - ls_addr        in   WIDTH  byte address
// - ls_wdata       in   WIDTH  store data, right-justified
// - ls_ready       out  1      1-cycle pulse: access done / ls_rdata valid
// - ls_rdata       out  WIDTH  extended load result
// - ls_misaligned  out  1      1-cycle pulse with ls_ready on a rejected access
// - bus_mem_read   out  1      to memory_bus mem_read
// - bus_mem_write  out  1      to memory_bus mem_write
// - bus_addr       out  WIDTH  to memory_bus addr_in
// - bus_wdata      out  WIDTH  to memory_bus data_in
// - bus_byteen     out  4      to memory_bus byteen
// - bus_rdata      in   WIDTH  from memory_bus mem_data_out; valid the cycle after the address is driven
// BEHAVIOUR
// - FSM states: IDLE, ACCESS, RESP, ERR.
//   - IDLE -> ACCESS on grant.
//   - IDLE -> ERR on a misaligned ls grant.
//   - ACCESS -> RESP.
//   - RESP -> IDLE.
//   - ERR -> IDLE.
// - Requests are sampled only in IDLE. Request fields are latched at grant; later changes are ignored until ready.
// - Arbitration: if only one request is pending, grant it. If both are pending, grant the side not granted last (last_grant flop, reset = fetch). No starvation.
// - Timing (grant at cycle N):
//   - N+1: ACCESS; bus_addr/bus_mem_read/bus_mem_write/bus_byteen/bus_wdata driven from registers.
//   - N+2: RESP; bus_rdata captured, the matching ready pulses, rdata/instr valid that cycle and held until the next RESP.
//   - Fixed latency of 2 cycles; at best one access per 3 cycles.
// - Misaligned cases: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
//   - ERR at N+1; ls_ready=ls_misaligned=1; no bus strobe; ls_rdata unchanged.
// - Writes: bus_mem_write is high only in ACCESS and only for stores; loads and fetches assert bus_mem_read only in ACCESS.
// - Byte enables (addr bits from ls_addr):
//   - byte: 4'b0001<<addr[1:0]
//   - half: 4'b0011<<{addr[1],1'b0}
//   - word: 4'b1111
//   - fetch: 4'b1111
// - Store data replication: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
// - Load extraction: shift bus_rdata right by addr[1:0]*8, take 8/16/32 bits, sign-extend unless ls_unsigned.
// - bus_addr: the full byte address is driven; memory_bus drops bits [1:0].
// - Reset values: state IDLE; all outputs 0 (bus_*, ready, misaligned, if_instr, ls_rdata).
// - Reset mid-operation: the in-flight access is dropped with no ready pulse; a write pending in ACCESS is suppressed in the reset cycle; the requester re-issues.
// - Requests present in a RESP or ERR cycle are not granted until IDLE.
// STRUCTURE
// - mem_pkg: mem_size_e (SZ_B/SZ_H/SZ_W), mac_state_e, grant_e.
// - Address map stays in defs.svh.
// - One sub-module, mem_align (combinational): byteen and replicated wdata from size/addr; load extract/extend from rdata/size/addr/unsigned.
// - Top level: FSM, arbiter, request latch.
// TESTING
// 1. Fetch if_addr=0x10, bus_rdata=0x00500093 at N+2 -> if_ready at N+2 only; if_instr=0x00500093; bus_mem_write never 1.
// 2. Store byte 0xAB at 0x2003 -> ACCESS cycle: byteen=4'b1000, bus_wdata=0xABABABAB, bus_mem_write=1 for one cycle; ls_ready at N+2.
// 3. Load half signed at 0x2002 with bus_rdata=0x8001_1234 -> ls_rdata=0xFFFF8001. Unsigned -> 0x00008001. Byte signed at 0x2001 -> 0x00000012.
// 4. Word load at 0x2006 -> ERR; ls_ready=ls_misaligned=1 at N+1; bus_mem_read/write stay 0.
// 5. if_req and ls_req both held for 4 grants -> grant order fetch, ls, fetch, ls (after reset); each ready pulses exactly once per grant.
// 6. Assert rst during ACCESS of a store -> no bus_mem_write that cycle; no ls_ready; all outputs 0 next cycle; a re-issued request completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory access controller: access sizes, FSM states,
// arbitration sides and the misalignment rule.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } mac_state_e;

  typedef enum logic {
    GR_IF = 1'b0,
    GR_LS = 1'b1
  } grant_e;

  // size 2'b11 has no encoding and is rejected like a misaligned access
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = a[0];
      SZ_W:    misaligned = (a != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store byte enables / data replication and load
// extraction with sign or zero extension. Purely combinational, 4 lanes.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteen,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (size)
      SZ_B: begin
        byteen    = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = uns ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        byteen    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        byteen    = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single bus master shared by instruction fetch and load/store: alternating
// arbiter, request latch and a fixed 2-cycle IDLE/ACCESS/RESP sequence.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_ready,
  output logic [WIDTH-1:0] if_instr,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [1:0]       ls_size,
  input  logic             ls_unsigned,
  input  logic [WIDTH-1:0] ls_addr,
  input  logic [WIDTH-1:0] ls_wdata,
  output logic             ls_ready,
  output logic [WIDTH-1:0] ls_rdata,
  output logic             ls_misaligned,
  output logic             bus_mem_read,
  output logic             bus_mem_write,
  output logic [WIDTH-1:0] bus_addr,
  output logic [WIDTH-1:0] bus_wdata,
  output logic [3:0]       bus_byteen,
  input  logic [WIDTH-1:0] bus_rdata
);

  mac_state_e       state_q, state_d;
  grant_e           last_grant_q, last_grant_d, side_q, side_d;
  logic             fresh_q, fresh_d;
  logic             we_q, we_d, uns_q, uns_d;
  logic [1:0]       size_q, size_d;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [WIDTH-1:0] if_instr_q, if_instr_d, ls_rdata_q, ls_rdata_d;
  logic             gnt_if, gnt_ls, in_access, in_resp, in_err;
  logic [3:0]       al_byteen;
  logic [WIDTH-1:0] al_wdata, al_rdata;

  mem_align u_align (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .uns       (uns_q),
    .wdata     (wdata_q),
    .rdata     (bus_rdata),
    .byteen    (al_byteen),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  // fresh_q: no grant since reset, so the first contested grant goes to fetch
  assign gnt_if = if_req && (!ls_req || fresh_q || (last_grant_q == GR_LS));
  assign gnt_ls = ls_req && !gnt_if;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    side_d       = side_q;
    fresh_d      = fresh_q;
    we_d         = we_q;
    uns_d        = uns_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_instr_d   = if_instr_q;
    ls_rdata_d   = ls_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_if) begin
          side_d       = GR_IF;
          last_grant_d = GR_IF;
          fresh_d      = 1'b0;
          we_d         = 1'b0;
          uns_d        = 1'b0;
          size_d       = SZ_W;
          addr_d       = if_addr;
          wdata_d      = '0;
          state_d      = ST_ACCESS;
        end else if (gnt_ls) begin
          side_d       = GR_LS;
          last_grant_d = GR_LS;
          fresh_d      = 1'b0;
          we_d         = ls_we;
          uns_d        = ls_unsigned;
          size_d       = ls_size;
          addr_d       = ls_addr;
          wdata_d      = ls_wdata;
          state_d      = misaligned(ls_size, ls_addr[1:0]) ? ST_ERR : ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        state_d = ST_IDLE;
        if (side_q == GR_IF) if_instr_d = bus_rdata;
        else if (!we_q)      ls_rdata_d = al_rdata;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GR_IF;
      side_q       <= GR_IF;
      fresh_q      <= 1'b1;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_instr_q   <= '0;
      ls_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      side_q       <= side_d;
      fresh_q      <= fresh_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_instr_q   <= if_instr_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  // rst gates strobes and pulses so an in-flight access dies in the reset cycle
  assign in_access = (state_q == ST_ACCESS) && !rst;
  assign in_resp   = (state_q == ST_RESP) && !rst;
  assign in_err    = (state_q == ST_ERR) && !rst;

  assign bus_mem_read  = in_access && !we_q;
  assign bus_mem_write = in_access && we_q;
  assign bus_addr      = in_access ? addr_q : '0;
  assign bus_byteen    = in_access ? al_byteen : 4'b0000;
  assign bus_wdata     = (in_access && we_q) ? al_wdata : '0;

  assign if_ready      = in_resp && (side_q == GR_IF);
  assign ls_ready      = (in_resp && (side_q == GR_LS)) || in_err;
  assign ls_misaligned = in_err;
  assign if_instr      = if_ready ? bus_rdata : if_instr_q;
  assign ls_rdata      = (in_resp && (side_q == GR_LS) && !we_q) ? al_rdata : ls_rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Table-driven bench for mem_access_ctrl with a ready-pulse scoreboard and
// hand sequences for arbitration and mid-access reset.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic        clk, rst;
  logic        if_req, if_ready;
  logic [31:0] if_addr, if_instr;
  logic        ls_req, ls_we, ls_unsigned, ls_ready, ls_misaligned;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        bus_mem_read, bus_mem_write;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byteen;

  mem_access_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_instr(if_instr),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .ls_misaligned(ls_misaligned),
    .bus_mem_read(bus_mem_read), .bus_mem_write(bus_mem_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_byteen(bus_byteen), .bus_rdata(bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        is_ls;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_data;
    logic        exp_mis;
  } vec_t;

  typedef struct packed {
    logic        is_ls;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  exp_t sb[$];
  vec_t vecs[14];
  int   n_pass = 0;
  int   n_total = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {23'b0, bus_mem_read, bus_mem_write, bus_byteen, if_ready, ls_ready,
        ls_misaligned}, 32'h0);
    chk({tag, "_addr"}, bus_addr, 32'h0);
    chk({tag, "_wdata"}, bus_wdata, 32'h0);
    chk({tag, "_instr"}, if_instr, 32'h0);
    chk({tag, "_rdata"}, ls_rdata, 32'h0);
  endtask

  // Scoreboard: every ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && (if_ready || ls_ready)) begin
      if (sb.size() == 0) chk("unexpected_ready", {30'b0, if_ready, ls_ready}, 32'h0);
      else begin
        e = sb.pop_front();
        chk("ready_side", {30'b0, if_ready, ls_ready}, e.is_ls ? 32'h1 : 32'h2);
        chk(e.is_ls ? "ls_rdata" : "if_instr", e.is_ls ? ls_rdata : if_instr, e.data);
        chk("misaligned", {31'b0, ls_misaligned}, {31'b0, e.mis});
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    int cyc, strobes;
    bit done;
    @(negedge clk);
    bus_rdata = v.rdata;
    if (v.is_ls) begin
      ls_req = 1'b1; ls_we = v.we; ls_size = v.size; ls_unsigned = v.uns;
      ls_addr = v.addr; ls_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    sb.push_back('{v.is_ls, v.exp_data, v.exp_mis});
    cyc = 0; strobes = 0; done = 1'b0;
    while (!done && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (bus_mem_read || bus_mem_write) begin
        strobes++;
        chk({tag, "_strobe_cyc"}, cyc, 32'd1);
        chk({tag, "_wr"}, {31'b0, bus_mem_write}, {31'b0, v.is_ls & v.we});
        chk({tag, "_addr"}, bus_addr, v.addr);
        chk({tag, "_be"}, {28'b0, bus_byteen}, {28'b0, v.exp_be});
        if (v.is_ls && v.we) chk({tag, "_wd"}, bus_wdata, v.exp_wd);
      end
      if (v.is_ls ? ls_ready : if_ready) begin
        done = 1'b1;
        chk({tag, "_latency"}, cyc, v.exp_mis ? 32'd1 : 32'd2);
        if_req = 1'b0; ls_req = 1'b0;
      end
    end
    if (!done) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      if_req = 1'b0; ls_req = 1'b0;
    end
    chk({tag, "_strobes"}, strobes, v.exp_mis ? 32'd0 : 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n_if, n_ls, reads, cyc;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_size = 2'b00; ls_unsigned = 1'b0; ls_addr = '0; ls_wdata = '0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check_zero("reset");
    mon_en = 1'b1;

    // is_ls we size uns addr wdata rdata | be wd data mis (data = held value when no load)
    vecs[0]  = '{N, N, 2'b10, N, 32'h10,   32'h0,        32'h00500093, 4'hF, 32'h0,        32'h00500093, N};
    vecs[1]  = '{Y, Y, 2'b00, N, 32'h2003, 32'h000000AB, 32'h0,        4'h8, 32'hABABABAB, 32'h0,        N};
    vecs[2]  = '{Y, N, 2'b01, N, 32'h2002, 32'h0,        32'h80011234, 4'hC, 32'h0,        32'hFFFF8001, N};
    vecs[3]  = '{Y, N, 2'b01, Y, 32'h2002, 32'h0,        32'h80011234, 4'hC, 32'h0,        32'h00008001, N};
    vecs[4]  = '{Y, N, 2'b00, N, 32'h2001, 32'h0,        32'h80011234, 4'h2, 32'h0,        32'h00000012, N};
    vecs[5]  = '{Y, N, 2'b10, N, 32'h2006, 32'h0,        32'h0,        4'h0, 32'h0,        32'h00000012, Y};
    vecs[6]  = '{Y, Y, 2'b01, N, 32'h2002, 32'hDEADBEEF, 32'h0,        4'hC, 32'hBEEFBEEF, 32'h00000012, N};
    vecs[7]  = '{Y, Y, 2'b10, N, 32'h2004, 32'hCAFEF00D, 32'h0,        4'hF, 32'hCAFEF00D, 32'h00000012, N};
    vecs[8]  = '{Y, N, 2'b00, N, 32'h2003, 32'h0,        32'h80FF0000, 4'h8, 32'h0,        32'hFFFFFF80, N};
    vecs[9]  = '{Y, N, 2'b00, Y, 32'h2000, 32'h0,        32'h123456F0, 4'h1, 32'h0,        32'h000000F0, N};
    vecs[10] = '{Y, N, 2'b11, N, 32'h2000, 32'h0,        32'h0,        4'h0, 32'h0,        32'h000000F0, Y};
    vecs[11] = '{Y, Y, 2'b01, N, 32'h2001, 32'h00001234, 32'h0,        4'h0, 32'h0,        32'h000000F0, Y};
    vecs[12] = '{Y, N, 2'b10, N, 32'h2008, 32'h0,        32'h89ABCDEF, 4'hF, 32'h0,        32'h89ABCDEF, N};
    vecs[13] = '{N, N, 2'b10, N, 32'h14,   32'h0,        32'h12345678, 4'hF, 32'h0,        32'h12345678, N};
    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset lands in the ACCESS cycle of a store
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_unsigned = 1'b0;
    ls_addr = 32'h2010; ls_wdata = 32'h55AA55AA;
    @(negedge clk);
    chk("rst_pre_write", {31'b0, bus_mem_write}, 32'h1);
    rst = 1'b1; ls_req = 1'b0;
    #1;
    chk("rst_write_suppressed", {31'b0, bus_mem_write}, 32'h0);
    chk("rst_no_ready", {31'b0, ls_ready}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_zero("rst_after");
    run_vec('{Y, Y, 2'b10, N, 32'h2010, 32'h55AA55AA, 32'h0, 4'hF, 32'h55AA55AA, 32'h0, N},
            "reissue");

    // Both sides held: grants must alternate starting with fetch after reset
    do_reset();
    sb.push_back('{1'b0, 32'h11112222, 1'b0});
    sb.push_back('{1'b1, 32'h11112222, 1'b0});
    sb.push_back('{1'b0, 32'h11112222, 1'b0});
    sb.push_back('{1'b1, 32'h11112222, 1'b0});
    @(negedge clk);
    bus_rdata = 32'h11112222;
    if_req = 1'b1; if_addr = 32'h20;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_unsigned = 1'b0; ls_addr = 32'h3000;
    n_if = 0; n_ls = 0; reads = 0; cyc = 0;
    while ((n_if < 2 || n_ls < 2) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus_mem_read) reads++;
      if (if_ready) begin n_if++; if (n_if == 2) if_req = 1'b0; end
      if (ls_ready) begin n_ls++; if (n_ls == 2) ls_req = 1'b0; end
    end
    if_req = 1'b0; ls_req = 1'b0;
    chk("arb_if_count", n_if, 32'd2);
    chk("arb_ls_count", n_ls, 32'd2);
    chk("arb_reads", reads, 32'd4);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
